// File: rtl/instr_exec_register_pkg.sv
// Shared types for the instruction register and its execution unit:
// operand/result/address types, opcode enum, instruction word and FSM states.
package instr_register_pkg;

    localparam int DEPTH       = 32;
    localparam int AW          = $clog2(DEPTH);
    localparam int ITER_CYCLES = 32;
    localparam int CNT_W       = $clog2(ITER_CYCLES);

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [AW-1:0]      address_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rezultat;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL_ITER,
        DIV_ITER,
        WRITEBACK
    } exec_state_t;

endpackage

// File: rtl/instr_exec_register_if.sv
// Write/read bus of the instruction register.
// master: driver side (write request, read pointer); slave: the register.
interface instr_exec_register_if;
    import instr_register_pkg::*;

    logic         load_en;
    address_t     write_pointer;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         word_valid;
    logic         busy;
    logic         exec_done;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b,
        output read_pointer,
        input  instruction_word, word_valid, busy, exec_done
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b,
        input  read_pointer,
        output instruction_word, word_valid, busy, exec_done
    );

endinterface

// File: rtl/instr_exec_register_iter_muldiv.sv
// Sequential radix-2 unsigned multiplier / restoring divider on magnitudes.
// Ports: clk, reset, start, mode (1=mul, 0=div), mag_a, mag_b, done, result.
module iter_muldiv
    import instr_register_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] mag_a,
    input  logic [31:0] mag_b,
    output logic        done,
    output logic [63:0] result
);

    // mul: acc = {partial product, multiplier}
    // div: acc = {remainder, quotient/dividend}
    logic [63:0]      acc;
    logic [63:0]      acc_nxt;
    logic [31:0]      opnd;
    logic             mode_q;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [32:0]      sum;
    logic [32:0]      part;
    logic [32:0]      diff;

    always_comb begin
        acc_nxt = acc;
        sum     = '0;
        part    = acc[63:31];
        diff    = part - {1'b0, opnd};
        if (mode_q) begin
            sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
            acc_nxt = {sum, acc[31:1]};
        end else if (part >= {1'b0, opnd}) begin
            acc_nxt = {diff[31:0], acc[30:0], 1'b1};
        end else begin
            acc_nxt = {part[31:0], acc[30:0], 1'b0};
        end
    end

    // High during the cycle whose closing edge performs the last step.
    assign done   = run && (cnt == CNT_W'(ITER_CYCLES - 1));
    assign result = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            mode_q <= 1'b0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            mode_q <= mode;
            opnd   <= mode ? mag_a : mag_b;
            acc    <= {32'd0, mode ? mag_b : mag_a};
        end else if (run) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_exec_register.sv
// 32-slot instruction register with single-cycle ALU and multi-cycle mul/div.
// Ports: clk, reset (sync, active-high), bus (slave side of the register bus).
module instr_exec_register
    import instr_register_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    instr_exec_register_if.slave bus
);

    instruction_t   slots [DEPTH];
    logic [DEPTH-1:0] valid;

    exec_state_t state_q;
    exec_state_t state_d;
    logic        accept;
    logic        is_multi;
    logic        busy_w;

    result_t      ext_a;
    result_t      ext_b;
    result_t      alu_res;
    result_t      wb_res;
    instruction_t new_word;
    logic [31:0]  mag_a;
    logic [31:0]  mag_b;
    logic [63:0]  q64;
    logic [63:0]  r64;

    opcode_t  op_q;
    address_t addr_q;
    logic     neg_q;
    logic     sa_q;
    logic     bz_q;

    logic        md_done;
    logic [63:0] md_res;

    always_comb begin
        ext_a    = {{32{bus.operand_a[31]}}, bus.operand_a};
        ext_b    = {{32{bus.operand_b[31]}}, bus.operand_b};
        mag_a    = bus.operand_a[31] ? 32'(-bus.operand_a) : bus.operand_a;
        mag_b    = bus.operand_b[31] ? 32'(-bus.operand_b) : bus.operand_b;
        is_multi = bus.opcode inside {MULT, DIV, MOD};
        busy_w   = (state_q != IDLE);
        accept   = bus.load_en && !busy_w;
        alu_res  = '0;
        unique case (bus.opcode)
            PASSA:   alu_res = ext_a;
            PASSB:   alu_res = ext_b;
            ADD:     alu_res = ext_a + ext_b;
            SUB:     alu_res = ext_a - ext_b;
            default: alu_res = '0;
        endcase
        new_word.opc      = bus.opcode;
        new_word.op_a     = bus.operand_a;
        new_word.op_b     = bus.operand_b;
        new_word.rezultat = is_multi ? '0 : alu_res;
    end

    assign bus.busy = busy_w;

    // Signs are reapplied to the unsigned magnitudes at writeback.
    always_comb begin
        q64    = {32'd0, md_res[31:0]};
        r64    = {32'd0, md_res[63:32]};
        wb_res = '0;
        unique case (op_q)
            MULT:    wb_res = neg_q ? -md_res : md_res;
            DIV:     wb_res = bz_q ? '0 : (neg_q ? -q64 : q64);
            MOD:     wb_res = bz_q ? '0 : (sa_q ? -r64 : r64);
            default: wb_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && is_multi) begin
                    state_d = (bus.opcode == MULT) ? MUL_ITER : DIV_ITER;
                end
            end
            MUL_ITER, DIV_ITER: begin
                if (md_done) begin
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            valid                <= '0;
            bus.instruction_word <= '0;
            bus.word_valid       <= 1'b0;
            bus.exec_done        <= 1'b0;
            op_q                 <= ZERO;
            addr_q               <= '0;
            neg_q                <= 1'b0;
            sa_q                 <= 1'b0;
            bz_q                 <= 1'b0;
        end else begin
            // Read samples pre-write contents: same-edge writes show next cycle.
            bus.instruction_word <= slots[bus.read_pointer];
            bus.word_valid       <= valid[bus.read_pointer];
            bus.exec_done        <= (accept && !is_multi)
                                 || (state_q == WRITEBACK);
            if (accept) begin
                slots[bus.write_pointer] <= new_word;
                valid[bus.write_pointer] <= !is_multi;
                op_q   <= bus.opcode;
                addr_q <= bus.write_pointer;
                neg_q  <= bus.operand_a[31] ^ bus.operand_b[31];
                sa_q   <= bus.operand_a[31];
                bz_q   <= (bus.operand_b == '0);
            end
            if (state_q == WRITEBACK) begin
                slots[addr_q].rezultat <= wb_res;
                valid[addr_q]          <= 1'b1;
            end
        end
    end

    iter_muldiv u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_multi),
        .mode   (bus.opcode == MULT),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .done   (md_done),
        .result (md_res)
    );

endmodule

// File: tb/tb_instr_exec_register.sv
// Directed self-checking bench for instr_exec_register.
// Drives the register bus and checks reads, busy timing and exec_done.
module tb_instr_exec_register;
    import instr_register_pkg::*;

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    instr_exec_register_if bus ();

    instr_exec_register dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [131:0] obs,
                         input logic [131:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input address_t wp, input opcode_t op,
                         input operand_t a, input operand_t b);
        bus.load_en       = en;
        bus.write_pointer = wp;
        bus.opcode        = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
    endtask

    task automatic read_check(input string tag, input address_t p,
                              input result_t exp_r, input logic exp_v);
        bus.read_pointer = p;
        tick();
        check({tag, "_res"}, bus.instruction_word.rezultat, exp_r);
        check({tag, "_vld"}, bus.word_valid, exp_v);
    endtask

    // Accepts a multi-cycle op, meanwhile tries to write slot 6, then
    // checks busy length, exec_done pulse count and the final slot.
    task automatic run_multi(input string tag, input address_t slot,
                             input opcode_t op, input operand_t a,
                             input operand_t b, input result_t exp_r);
        int busy_cnt;
        int done_cnt;
        drive(1'b1, slot, op, a, b);
        bus.read_pointer = slot;
        tick();
        busy_cnt = bus.busy ? 1 : 0;
        done_cnt = bus.exec_done ? 1 : 0;
        drive(1'b1, 5'd6, ADD, 32'sd1, 32'sd2);
        for (int i = 0; i < 40; i++) begin
            if (i == 4) begin
                bus.load_en = 1'b0;
            end
            tick();
            if (bus.busy) busy_cnt++;
            if (bus.exec_done) done_cnt++;
            if (i == 10) begin
                check({tag, "_fl_res"}, bus.instruction_word.rezultat, 64'd0);
                check({tag, "_fl_vld"}, bus.word_valid, 1'b0);
                check({tag, "_fl_opa"}, bus.instruction_word.op_a, a);
            end
        end
        check({tag, "_busy_cycles"}, busy_cnt, 33);
        check({tag, "_done_pulses"}, done_cnt, 1);
        read_check(tag, slot, exp_r, 1'b1);
    endtask

    initial begin
        int done_cnt;
        reset            = 1'b1;
        bus.read_pointer = '0;
        drive(1'b0, '0, ZERO, '0, '0);
        tick();
        tick();
        reset = 1'b0;

        for (int p = 0; p < DEPTH; p++) begin
            bus.read_pointer = address_t'(p);
            tick();
            check("rst_word", bus.instruction_word, '0);
            check("rst_vld", bus.word_valid, 1'b0);
            check("rst_busy", bus.busy, 1'b0);
        end

        drive(1'b1, 5'd31, ADD, -32'sd7, 32'sd12);
        tick();
        check("add_done", bus.exec_done, 1'b1);
        check("add_busy", bus.busy, 1'b0);
        drive(1'b1, 5'd30, SUB, 32'sd3, 32'sd10);
        tick();
        check("sub_busy", bus.busy, 1'b0);
        drive(1'b1, 5'd29, PASSB, 32'sd0, 32'sd9);
        tick();
        check("passb_busy", bus.busy, 1'b0);
        bus.load_en = 1'b0;
        read_check("add", 5'd31, 64'sd5, 1'b1);
        check("idle_done", bus.exec_done, 1'b0);
        check("add_opc", bus.instruction_word.opc, ADD);
        read_check("sub", 5'd30, -64'sd7, 1'b1);
        read_check("passb", 5'd29, 64'sd9, 1'b1);

        run_multi("mult", 5'd5, MULT, -32'sd15, 32'sd13, -64'sd195);
        read_check("slot6", 5'd6, 64'sd0, 1'b0);
        check("slot6_word", bus.instruction_word, '0);
        run_multi("div", 5'd10, DIV, -32'sd15, 32'sd4, -64'sd3);
        run_multi("mod", 5'd11, MOD, -32'sd15, 32'sd4, -64'sd3);
        run_multi("div0", 5'd12, DIV, 32'sd7, 32'sd0, 64'sd0);
        run_multi("mod0", 5'd13, MOD, 32'sd7, 32'sd0, 64'sd0);
        read_check("slot6_end", 5'd6, 64'sd0, 1'b0);

        drive(1'b1, 5'd2, ADD, 32'sd1, 32'sd1);
        tick();
        drive(1'b1, 5'd2, PASSA, -32'sd4, 32'sd0);
        bus.read_pointer = 5'd2;
        tick();
        check("rdw_old", bus.instruction_word.rezultat, 64'sd2);
        bus.load_en = 1'b0;
        tick();
        check("rdw_new", bus.instruction_word.rezultat, -64'sd4);
        check("rdw_opc", bus.instruction_word.opc, PASSA);

        drive(1'b1, 5'd8, MULT, 32'sd11, 32'sd11);
        tick();
        check("rmo_busy_on", bus.busy, 1'b1);
        bus.load_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        check("rmo_busy_off", bus.busy, 1'b0);
        check("rmo_done", bus.exec_done, 1'b0);
        check("rmo_word", bus.instruction_word, '0);
        reset    = 1'b0;
        done_cnt = 0;
        bus.read_pointer = 5'd8;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.exec_done) done_cnt++;
        end
        check("rmo_no_done", done_cnt, 0);
        check("rmo_slot8", bus.instruction_word, '0);
        check("rmo_slot8_vld", bus.word_valid, 1'b0);
        read_check("rmo_slot5", 5'd5, 64'sd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_exec_register.md
Name: instr_exec_register

Overview:
- 32-entry instruction register with an integrated execution unit. This is the design-under-test side of the instruction-register write/read interface.
- The write port captures opcode and operands into a slot. The unit then computes the 64-bit result and stores it in the same slot.
- The read port returns the full instruction word (opc, op_a, op_b, rezultat) plus a result-valid flag.
- Sits between the stimulus/driver side and any result consumer.

Parameters:
- DEPTH, 32, number of slots; address width is $clog2(DEPTH) = 5.
- ITER_CYCLES, 32, iteration count of the multi-cycle mul/div unit; must equal operand width.

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- load_en  input  1  write request; accepted when load_en=1 and busy=0 at posedge
- write_pointer  input  5 (address_t)  target slot
- opcode  input  4 (opcode_t)  operation
- operand_a  input  32 (operand_t, signed)  first operand
- operand_b  input  32 (operand_t, signed)  second operand
- read_pointer  input  5 (address_t)  slot to read
- instruction_word  output  instruction_t (4+32+32+64)  registered read data
- word_valid  output  1  rezultat of the read slot is final
- busy  output  1  multi-cycle operation in progress; writes ignored
- exec_done  output  1  one-cycle pulse when a result is written to a slot

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, reset.
- Reset, on any posedge with reset=1:
  - every slot and valid bit cleared to 0
  - instruction_word=0, word_valid=0, busy=0, exec_done=0
  - FSM to IDLE; any in-flight operation is aborted and its result discarded
- Accept: on a posedge with load_en=1, busy=0 and reset=0, the slot gets {opc, op_a, op_b}.
- Single-cycle ops (ZERO, PASSA, PASSB, ADD, SUB):
  - rezultat written in the same edge; valid=1; exec_done=1 next cycle; busy stays 0.
- Multi-cycle ops (MULT, DIV, MOD), accepted at edge N:
  - slot valid=0 and rezultat=0 at N
  - busy=1 from N through the cycle after N+32
  - result written to the latched slot at N+33, valid=1, exec_done pulses for one cycle
  - busy=0 after N+33, so the earliest next accept is at N+34
- load_en while busy=1 is ignored: no slot change and no queueing.
- FSM states: IDLE -> (MULT) MUL_ITER | (DIV/MOD) DIV_ITER -> WRITEBACK -> IDLE.
  - Iteration counter runs 0..ITER_CYCLES-1.
  - Opcode, slot address and operand magnitudes are latched at accept.
- Arithmetic rules:
  - Operands are sign-extended to 64 bits.
  - ADD/SUB: 64-bit, so no overflow is possible.
  - MULT: full signed 64-bit product, radix-2 shift-add on magnitudes, sign applied at writeback.
  - DIV: quotient truncated toward zero.
  - MOD: remainder carries the sign of the dividend.
  - DIV or MOD with op_b=0 gives rezultat=0; the divider still runs its full latency.
  - Opcode values 8..15 give rezultat=0 and are treated as single-cycle.
- Read path:
  - instruction_word <= slot[read_pointer] every posedge; latency 1; no enable.
  - word_valid <= valid[read_pointer].
  - A read and write of the same address on the same edge returns the old content; the new content appears one cycle later.
  - A read of a slot whose multi-cycle op is in flight shows opc/op_a/op_b with rezultat=0 and word_valid=0.
- Writeback collision: none is possible, because busy blocks writes during multi-cycle ops.

Decomposition:
- instr_register_pkg holds:
  - operand_t (signed 32)
  - opcode_t enum {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD}, 4 bits
  - address_t (5)
  - result_t (signed 64)
  - instruction_t struct {opc, op_a, op_b, rezultat}
  - FSM state enum exec_state_t
- One sub-module: iter_muldiv, the sequential radix-2 multiplier/divider.
  - Inputs: start, mode, operands.
  - Outputs: done and 64-bit result.
- The slot array, single-cycle ALU and FSM stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles, sweep read_pointer 0..31 -> instruction_word=0, word_valid=0, busy=0 for all.
- Single-cycle ops: write slot 31 ADD a=-7 b=12; slot 30 SUB a=3 b=10; slot 29 PASSB b=9.
  - Read 31 -> rezultat=5, valid=1.
  - Read 30 -> -7.
  - Read 29 -> 9.
  - busy never asserted.
- MULT: write slot 5 MULT a=-15 b=13.
  - busy=1 for 33 cycles; exec_done one pulse.
  - Read 5 -> -195, valid=1.
  - load_en to slot 6 during busy -> slot 6 stays 0.
- DIV/MOD:
  - DIV a=-15 b=4 -> -3.
  - MOD a=-15 b=4 -> -3.
  - DIV a=7 b=0 -> 0.
  - MOD a=7 b=0 -> 0.
  - Each completes with a 33-cycle busy.
- Read-during-write: slot 2 holds ADD 1+1. Write slot 2 PASSA a=-4 while read_pointer=2 on the same edge.
  - First read returns rezultat=2.
  - Next cycle returns -4.
- Reset mid-op: start MULT a=11 b=11 into slot 8; assert reset 10 cycles after accept.
  - busy=0 next cycle, exec_done never pulses.
  - Slot 8 reads 0 with valid=0.
